// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS pipeline stages (Decode, ControlUnit,
// Writeback).
//   DATA_W / REG_ADDR_W : default datapath and register-number widths
//   LD_*                : 3-bit load-type encodings from the control unit
//   REG_ZERO            : register number of the hard-wired zero register
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_HU = 3'b010;
    localparam logic [2:0] LD_B  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/mips_load_extract.sv
// mips_load_extract: big-endian sub-word extraction for loads (combinational).
// Ports:
//   raw_word  in  DATA_W  aligned word from data memory
//   offset    in  2       byte offset (effective address bits 1:0)
//   load_type in  3       LD_* encoding; unknown encodings behave as lw
//   load_data out DATA_W  sign- or zero-extended result
module mips_load_extract #(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] raw_word,
    input  logic [1:0]        offset,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] load_data
);
    import mips_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Big-endian: byte 0 is the most significant byte of the word.
        byte_sel = '0;
        case (offset)
            2'd0: byte_sel = raw_word[31:24];
            2'd1: byte_sel = raw_word[23:16];
            2'd2: byte_sel = raw_word[15:8];
            2'd3: byte_sel = raw_word[7:0];
            default: byte_sel = '0;
        endcase

        // offset[0] is deliberately ignored for halfwords; misalignment is
        // trapped elsewhere, if at all.
        half_sel = offset[1] ? raw_word[15:0] : raw_word[31:16];

        load_data = raw_word;
        case (load_type)
            LD_W:    load_data = raw_word;
            LD_H:    load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_HU:   load_data = {{(DATA_W-16){1'b0}}, half_sel};
            LD_B:    load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_BU:   load_data = {{(DATA_W-8){1'b0}}, byte_sel};
            default: load_data = raw_word;
        endcase
    end

endmodule

// File: rtl/mips_writeback_stage.sv
// mips_writeback_stage: MEM/WB pipeline register, load alignment and the
// write-back mux of the 5-stage MIPS pipeline.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   stall, flush             hold MEM/WB / load a bubble (flush wins)
//   mem_*                    MEM-stage instruction fields
//   dec_rs, dec_rt           Decode read-port register numbers
//   RegWrite, write_reg,
//   write_data               register-file write port
//   fwd_rs_hit, fwd_rt_hit,
//   fwd_data                 write-before-read bypass to Decode
//   retired_count            instructions retired since reset (wraps)
//
// Handshake: none; the stage is a plain pipeline register. An instruction
// retires on the edge at which it leaves WB, i.e. when valid and either not
// stalled or being flushed out.
module mips_writeback_stage #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic                  mem_memto_reg,
    input  logic [2:0]            mem_load_type,
    input  logic [DATA_W-1:0]     mem_alu_result,
    input  logic [DATA_W-1:0]     mem_read_data,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,
    input  logic [REG_ADDR_W-1:0] dec_rs,
    input  logic [REG_ADDR_W-1:0] dec_rt,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic                  fwd_rs_hit,
    output logic                  fwd_rt_hit,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [CNT_W-1:0]      retired_count
);
    import mips_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic                  valid_q;
    logic                  reg_write_q;
    logic                  memto_reg_q;
    logic [2:0]            load_type_q;
    logic [DATA_W-1:0]     alu_result_q;
    logic [DATA_W-1:0]     read_data_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_W-1:0]     load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            memto_reg_q  <= 1'b0;
            load_type_q  <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            write_reg_q  <= '0;
            count_q      <= '0;
        end else begin
            // The WB instruction retires when it leaves the stage; a flush
            // replaces MEM/WB but the instruction already in WB still writes.
            if (valid_q && (!stall || flush)) begin
                count_q <= count_q + CNT_ONE;
            end

            if (flush) begin
                valid_q      <= 1'b0;
                reg_write_q  <= 1'b0;
                memto_reg_q  <= 1'b0;
                load_type_q  <= '0;
                alu_result_q <= '0;
                read_data_q  <= '0;
                write_reg_q  <= '0;
            end else if (!stall) begin
                valid_q      <= mem_valid;
                reg_write_q  <= mem_reg_write;
                memto_reg_q  <= mem_memto_reg;
                load_type_q  <= mem_load_type;
                alu_result_q <= mem_alu_result;
                read_data_q  <= mem_read_data;
                write_reg_q  <= mem_write_reg;
            end
        end
    end

    mips_load_extract #(
        .DATA_W (DATA_W)
    ) u_load_extract (
        .raw_word  (read_data_q),
        .offset    (alu_result_q[1:0]),
        .load_type (load_type_q),
        .load_data (load_data)
    );

    // $0 is never written, so it is also never a bypass source.
    assign RegWrite      = valid_q && reg_write_q && (write_reg_q != REG_ZERO);
    assign write_reg     = write_reg_q;
    assign write_data    = memto_reg_q ? load_data : alu_result_q;
    assign fwd_rs_hit    = RegWrite && (dec_rs == write_reg_q);
    assign fwd_rt_hit    = RegWrite && (dec_rt == write_reg_q);
    assign fwd_data      = write_data;
    assign retired_count = count_q;

endmodule

// File: doc/mips_writeback_stage.md
Name: mips_writeback_stage

Overview:
- Stage 5 of the pipelined MIPS: MEM/WB pipeline register, load-data alignment and the write-back mux.
- Drives the register-file write port (RegWrite, write_reg, write_data) that Decode consumes.
- Provides write-before-read bypass values for Decode's two read ports.
- Keeps a retired-instruction counter.

Parameters:
DATA_W, 32, datapath width (only 32 supported for load extraction)
REG_ADDR_W, 5, register-number width
CNT_W, 32, retired-instruction counter width

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold the MEM/WB register contents
flush  input  1  load a bubble into MEM/WB instead of MEM-stage data
mem_valid  input  1  MEM stage holds a real instruction
mem_reg_write  input  1  instruction writes a register
mem_memto_reg  input  1  1 = write loaded data, 0 = write ALU result
mem_load_type  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; others treated as lw
mem_alu_result  input  DATA_W  ALU result / effective address
mem_read_data  input  DATA_W  raw aligned word from data memory
mem_write_reg  input  REG_ADDR_W  destination register (RegDst already applied)
dec_rs  input  REG_ADDR_W  Decode read port 1 register number
dec_rt  input  REG_ADDR_W  Decode read port 2 register number
RegWrite  output  1  register-file write enable
write_reg  output  REG_ADDR_W  register-file write address
write_data  output  DATA_W  register-file write data
fwd_rs_hit  output  1  write_data must replace read_data1
fwd_rt_hit  output  1  write_data must replace read_data2
fwd_data  output  DATA_W  bypass value (equals write_data)
retired_count  output  CNT_W  instructions retired since reset

Behaviour:
- The MEM/WB register stores valid, reg_write, memto_reg, load_type, alu_result, read_data and write_reg.
- Update priority at each rising edge: rst > flush > stall > load.
  - rst: every field is 0; retired_count is 0.
  - flush: valid=0 and all other fields 0. The instruction currently in WB still retires this cycle.
  - stall (without flush): all fields hold.
  - Otherwise the register captures the mem_* inputs.
- Outputs are combinational from the register, giving 1 cycle of latency from MEM inputs to the write port.
- RegWrite = valid & reg_write & (write_reg != 0). A write to $0 is never issued.
- write_reg equals the stored write_reg, including 0 after reset.
- Load extraction is big-endian, with offset = alu_result[1:0]:
  - lb/lbu: byte 0 = bits 31:24, byte 3 = bits 7:0. lb sign-extends; lbu zero-extends.
  - lh/lhu: alu_result[1]=0 selects bits 31:16, 1 selects bits 15:0. alu_result[0] is ignored (misalignment is not trapped here). lh sign-extends; lhu zero-extends.
  - lw: the word passes through unchanged.
- write_data = memto_reg ? extracted_load : alu_result.
- write_data is driven even when RegWrite=0; it is don't-care for checking but must be deterministic (0 after reset).
- Bypass:
  - fwd_rs_hit = RegWrite & (dec_rs == write_reg).
  - fwd_rt_hit = RegWrite & (dec_rt == write_reg).
  - fwd_data = write_data.
  - The hit flags are purely combinational on dec_rs/dec_rt. No extra cycle.
- Stalled cycles: RegWrite stays asserted. Repeated writes of the same value are idempotent and allowed.
- retired_count increments by 1 at an edge where valid=1 and (stall=0 or flush=1), and not rst.
  - It counts once per instruction.
  - It wraps modulo 2^CNT_W.
  - Bubbles (valid=0) are never counted, even with reg_write set.
- Reset mid-stall or mid-flush: rst wins, and the same-cycle retire is not counted.

Decomposition:
- Shared package mips_pkg holds:
  - load-type constants LD_W, LD_H, LD_HU, LD_B, LD_BU (3-bit);
  - REG_ZERO;
  - DATA_W/REG_ADDR_W defaults, shared with Decode and ControlUnit.
- One natural sub-module: mips_load_extract (combinational; inputs raw word, offset, load_type; output DATA_W word).

Test Plan:
- Reset: assert rst 2 cycles with mem_valid=1, reg_write=1, write_reg=5 -> RegWrite=0, write_reg=0, write_data=0, retired_count=0 during and 1 cycle after release.
- ALU write-back: valid, reg_write, memto_reg=0, write_reg=8, alu_result=0x0000_1234 -> next cycle RegWrite=1, write_reg=8, write_data=0x1234; retired_count=1 one edge later.
- Loads with raw word 0x80FF_7F01:
  - lb at offset 0 -> 0xFFFF_FF80;
  - lbu at offset 1 -> 0x0000_00FF;
  - lh at offset 2 -> 0x0000_7F01;
  - lhu at offset 0 -> 0x0000_80FF;
  - lw -> 0x80FF_7F01.
- $0 suppression and bypass: write_reg=0 with reg_write=1 -> RegWrite=0, fwd hits 0. Then write_reg=9, dec_rs=9, dec_rt=3 -> fwd_rs_hit=1, fwd_rt_hit=0, fwd_data=write_data.
- Stall/flush:
  - Stall 3 cycles holding a valid instruction -> outputs constant, retired_count increments exactly once.
  - Then flush with stall=1 -> next cycle valid=0, RegWrite=0.
  - Simultaneous rst+flush -> reset state, no count.
- Counter wrap: with CNT_W=4, retire 17 valid instructions -> retired_count=1.
